// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between instruction fetch and the
// load/store stage. Load/store has priority, with a starvation guard for fetch.
// It also performs byte-lane steering, load extension and access-error flagging.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [2:0]  ls_size_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        hold_o
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_LS} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_off;
  logic        r_err;
  logic        ls_err;
  logic        ls_rd;
  logic [31:0] ld_shift;

  // Fetch address byte offset is meaningless for word fetches.
  logic unused_if_off;
  assign unused_if_off = ^if_addr_i[1:0];

  // Combinational arbitration: LS first unless fetch has been starved.
  assign if_gnt_o = if_req_i && (!ls_req_i || (starve_cnt == STARVE_LIM));
  assign ls_gnt_o = ls_req_i && !if_gnt_o;
  assign hold_o   = ls_req_i && !ls_gnt_o;
  // Erroring accesses and loads both produce a response on the LS port.
  assign ls_rd    = ls_gnt_o && (ls_err || !ls_we_i);

  // Decode misaligned or illegal-size load/store requests.
  always_comb begin
    ls_err = 1'b0;
    case (ls_size_i)
      3'b000, 3'b100: ls_err = 1'b0;
      3'b001, 3'b101: ls_err = ls_addr_i[0];
      3'b010:         ls_err = |ls_addr_i[1:0];
      default:        ls_err = 1'b1;
    endcase
  end

  // Drive the RAM port for the granted requester with lane steering.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (if_gnt_o) begin
      mem_req_o  = 1'b1;
      mem_be_o   = '1;
      mem_addr_o = {if_addr_i[31:2], 2'b00};
    end else if (ls_gnt_o && !ls_err) begin
      mem_req_o  = 1'b1;
      mem_we_o   = ls_we_i;
      mem_addr_o = {ls_addr_i[31:2], 2'b00};
      if (!ls_we_i) begin
        mem_be_o = '1;
      end else begin
        case (ls_size_i[1:0])
          2'b00: begin
            mem_be_o    = 4'b0001 << ls_addr_i[1:0];
            mem_wdata_o = {4{ls_wdata_i[7:0]}};
          end
          2'b01: begin
            mem_be_o    = ls_addr_i[1] ? 4'b1100 : 4'b0011;
            mem_wdata_o = {2{ls_wdata_i[15:0]}};
          end
          default: begin
            mem_be_o    = '1;
            mem_wdata_o = ls_wdata_i;
          end
        endcase
      end
    end
  end

  // Response FSM: remember which requester owns the returning read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      r_size <= '0;
      r_off  <= '0;
      r_err  <= 1'b0;
    end else if (if_gnt_o) begin
      state <= RD_IF;
    end else if (ls_rd) begin
      state  <= RD_LS;
      r_size <= ls_size_i;
      r_off  <= ls_addr_i[1:0];
      r_err  <= ls_err;
    end else begin
      state <= IDLE;
    end
  end

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req_i || if_gnt_o) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign ld_shift = mem_rdata_i >> {r_off, 3'b000};

  // Present read data, extending loads according to the registered size.
  always_comb begin
    if_rvalid_o = (state == RD_IF);
    if_rdata_o  = (state == RD_IF) ? mem_rdata_i : '0;
    ls_rvalid_o = (state == RD_LS);
    ls_err_o    = (state == RD_LS) && r_err;
    ls_rdata_o  = '0;
    if ((state == RD_LS) && !r_err) begin
      case (r_size)
        3'b000:  ls_rdata_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
        3'b100:  ls_rdata_o = {24'd0, ld_shift[7:0]};
        3'b001:  ls_rdata_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
        3'b101:  ls_rdata_o = {16'd0, ld_shift[15:0]};
        default: ls_rdata_o = ld_shift;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: byte-level reference memory and arbitration
// model predict grants and responses; a monitor checks responses from queues.
module tb_mem_arbiter;

  localparam int unsigned SM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_i, ls_req_i, ls_we_i;
  logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i;
  logic [2:0]  ls_size_i;
  logic        if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] if_rdata_o, ls_rdata_o;
  logic        mem_req_o, mem_we_o, hold_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .hold_o(hold_o)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned due; logic err; logic [31:0] data; } rsp_t;
  rsp_t if_q[$];
  rsp_t ls_q[$];

  logic [7:0]  ref_b [0:1023];   // reference memory, byte addressed
  logic [31:0] ram   [0:255];    // environment RAM driven by the DUT port
  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  logic        if_pend = 1'b0, ls_pend = 1'b0, p_we = 1'b0;
  logic [31:0] p_if_addr = '0, p_addr = '0, p_wdata = '0;
  logic [2:0]  p_size = '0;
  int unsigned m_starve = 0;
  logic        last_if_gnt = 1'b0;

  // Synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int k = 0; k < 4; k++)
          if (mem_be_o[k]) ram[mem_addr_o[9:2]][8*k +: 8] = mem_wdata_o[8*k +: 8];
      end else begin
        mem_rdata_i <= ram[mem_addr_o[9:2]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
  endfunction

  function automatic int width_of(input logic [2:0] sz);
    return (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic access_err(input logic [2:0] sz, input logic [31:0] a);
    if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7) return 1'b1;
    return (a % width_of(sz)) != 0;
  endfunction

  function automatic logic [31:0] load_val(input int a, input logic [2:0] sz);
    logic [31:0] v;
    int n;
    n = width_of(sz);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[a+i]) << (8*i));
    if (!sz[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!sz[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic poke(input int a, input logic [31:0] w);
    ram[a/4] = w;
    for (int k = 0; k < 4; k++) ref_b[(a & ~3) + k] = w[8*k +: 8];
  endtask

  task automatic drive();
    if_req_i   = if_pend;
    if_addr_i  = p_if_addr;
    ls_req_i   = ls_pend;
    ls_we_i    = p_we;
    ls_size_i  = p_size;
    ls_addr_i  = p_addr;
    ls_wdata_i = p_wdata;
  endtask

  // One clock cycle: predict grants, check the port, update the model.
  task automatic step();
    logic exp_if, exp_ls;
    logic [3:0] ebe;
    logic [31:0] ewd;
    int a, wa, n;
    drive();
    @(negedge clk); #2;
    exp_if = if_pend && (!ls_pend || m_starve == SM);
    exp_ls = ls_pend && !exp_if;
    last_if_gnt = if_gnt_o;
    chk("if_gnt", if_gnt_o, exp_if);
    chk("ls_gnt", ls_gnt_o, exp_ls);
    chk("hold", hold_o, ls_pend && !exp_ls);
    if (exp_if) begin
      chk("if_mem_req", mem_req_o, 1'b1);
      chk("if_mem_addr", mem_addr_o, p_if_addr & ~32'd3);
      if_q.push_back('{cyc + 1, 1'b0, word_at(int'(p_if_addr & ~32'd3))});
    end
    if (exp_ls) begin
      a  = int'(p_addr);
      wa = a & ~3;
      n  = width_of(p_size);
      if (access_err(p_size, p_addr)) begin
        chk("err_mem_req", mem_req_o, 1'b0);
        ls_q.push_back('{cyc + 1, 1'b1, 32'd0});
      end else begin
        chk("ls_mem_req", mem_req_o, 1'b1);
        chk("ls_mem_we", mem_we_o, p_we);
        chk("ls_mem_addr", mem_addr_o, 32'(wa));
        if (p_we) begin
          ebe = '0;
          for (int k = 0; k < 4; k++) ebe[k] = (wa + k >= a) && (wa + k < a + n);
          ewd = (n == 1) ? {4{p_wdata[7:0]}} : (n == 2) ? {2{p_wdata[15:0]}} : p_wdata;
          chk("st_be", 32'(mem_be_o), 32'(ebe));
          chk("st_wdata", mem_wdata_o, ewd);
          for (int i = 0; i < n; i++) ref_b[a+i] = p_wdata[8*i +: 8];
        end else begin
          chk("ld_be", 32'(mem_be_o), 32'hF);
          ls_q.push_back('{cyc + 1, 1'b0, load_val(a, p_size)});
        end
      end
    end
    if (!exp_if && !exp_ls) chk("idle_mem_req", mem_req_o, 1'b0);
    if (if_pend && !exp_if) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
    else m_starve = 0;
    @(posedge clk); #1;
    if (exp_if) if_pend = 1'b0;
    if (exp_ls) ls_pend = 1'b0;
    drive();
  endtask

  task automatic do_if(input logic [31:0] a);
    if_pend = 1'b1; p_if_addr = a;
    for (int i = 0; i < 8 && if_pend; i++) step();
  endtask

  task automatic do_ls(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    ls_pend = 1'b1; p_we = we; p_size = sz; p_addr = a; p_wdata = wd;
    for (int i = 0; i < 8 && ls_pend; i++) step();
  endtask

  // Both requesters held busy: fetch must win exactly every fifth cycle.
  task automatic starve_run(input int n);
    for (int i = 0; i < n; i++) begin
      if (!if_pend) begin if_pend = 1'b1; p_if_addr = 32'($urandom_range(0, 1023)); end
      if (!ls_pend) begin
        ls_pend = 1'b1; p_we = 1'b0; p_size = 3'b010;
        p_addr = 32'($urandom_range(0, 255) * 4);
      end
      step();
      chk("starve_pattern", last_if_gnt, (i % 5) == 4);
    end
  endtask

  // Response monitor: every rvalid must match the queued expectation due now.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk); #1;
      if (if_rvalid_o) begin
        if (if_q.size() == 0 || if_q[0].due != cyc) chk("if_rvalid_unexpected", 32'(if_rvalid_o), 32'd0);
        else begin r = if_q.pop_front(); chk("if_rdata", if_rdata_o, r.data); end
      end else begin
        chk("if_rdata_idle", if_rdata_o, 32'd0);
        if (if_q.size() != 0 && if_q[0].due == cyc) begin
          void'(if_q.pop_front());
          chk("if_rvalid_missing", 32'(if_rvalid_o), 32'd1);
        end
      end
      if (ls_rvalid_o) begin
        if (ls_q.size() == 0 || ls_q[0].due != cyc) chk("ls_rvalid_unexpected", 32'(ls_rvalid_o), 32'd0);
        else begin
          r = ls_q.pop_front();
          chk("ls_err", 32'(ls_err_o), 32'(r.err));
          chk("ls_rdata", ls_rdata_o, r.data);
        end
      end else begin
        chk("ls_err_idle", 32'(ls_err_o), 32'd0);
        chk("ls_rdata_idle", ls_rdata_o, 32'd0);
        if (ls_q.size() != 0 && ls_q[0].due == cyc) begin
          void'(ls_q.pop_front());
          chk("ls_rvalid_missing", 32'(ls_rvalid_o), 32'd1);
        end
      end
    end
  end

  initial begin
    drive();
    for (int i = 0; i < 256; i++) poke(i * 4, $urandom);
    poke(32'h10, 32'h0050_0093);
    poke(32'h100, 32'h80FF_1234);
    poke(32'h20, 32'h0000_0000);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_if_rvalid", 32'(if_rvalid_o), 32'd0);
    chk("rst_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_hold", 32'(hold_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back fetches, then sign/zero-extending loads.
    do_if(32'h10);
    do_if(32'h14);
    do_ls(1'b0, 3'b000, 32'h103, '0);
    do_ls(1'b0, 3'b100, 32'h103, '0);
    do_ls(1'b0, 3'b001, 32'h102, '0);
    do_ls(1'b0, 3'b101, 32'h102, '0);
    // Lane-steered stores with read-back.
    do_ls(1'b1, 3'b000, 32'h21, 32'h1234_56AB);
    do_ls(1'b1, 3'b001, 32'h22, 32'hCAFE_BEEF);
    do_ls(1'b0, 3'b010, 32'h20, '0);
    // Misaligned and illegal-size accesses.
    do_ls(1'b0, 3'b010, 32'h06, '0);
    do_ls(1'b0, 3'b011, 32'h08, '0);
    do_ls(1'b1, 3'b001, 32'h31, 32'h5555_5555);
    step();

    // Starvation guard.
    starve_run(10);
    if_pend = 1'b0;
    step();
    step();

    // Reset right after a load grant, with the starvation counter non-zero.
    starve_run(3);
    rst_n = 1'b0;
    if_q.delete(); ls_q.delete();
    if_pend = 1'b0; ls_pend = 1'b0; m_starve = 0;
    drive();
    @(negedge clk); #2;
    chk("rst_mid_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    step();
    starve_run(5);
    if_pend = 1'b0;
    step();

    // Randomized mixed traffic.
    for (int i = 0; i < 800; i++) begin
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1'b1; p_if_addr = 32'($urandom_range(0, 1023));
      end
      if (!ls_pend && $urandom_range(0, 2) != 0) begin
        ls_pend = 1'b1;
        p_we    = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) p_size = p_we ? 3'b011 : 3'($urandom_range(6, 7));
        else if (p_we) p_size = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: p_size = 3'b000;
            1: p_size = 3'b001;
            2: p_size = 3'b010;
            3: p_size = 3'b100;
            default: p_size = 3'b101;
          endcase
        end
        p_addr  = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) == 0) p_addr = p_addr & ~32'(width_of(p_size) - 1);
        p_wdata = $urandom;
      end
      step();
    end
    if_pend = 1'b0; ls_pend = 1'b0;
    repeat (3) step();
    chk("if_queue_drained", 32'(if_q.size()), 32'd0);
    chk("ls_queue_drained", 32'(ls_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and load/store sequencer placed between the instruction-fetch path, the load/store stage that follows the decoder (LB/LH/LW/LBU/LHU/SB/SH/SW), and one shared synchronous 32-bit RAM. It grants one requester per cycle, with load/store priority and a starvation guard for fetch. It performs byte-lane steering and sign/zero extension, and flags misaligned or illegal accesses. It drives a hold to the pipeline while a load/store waits for the port.

## Interface
Parameters:
- `STARVE_MAX`, 4: number of consecutive denied fetch cycles after which fetch wins priority for one grant (range 1..15).

Ports (clock and reset use one clock; reset is asynchronous, active-low):
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `if_req_i` in 1: fetch read request.
- `if_addr_i` in 32: fetch byte address; bits [1:0] ignored.
- `if_gnt_o` out 1: fetch request accepted this cycle.
- `if_rvalid_o` out 1: fetch data valid.
- `if_rdata_o` out 32: fetched word.
- `ls_req_i` in 1: load/store request.
- `ls_we_i` in 1: 1 = store, 0 = load.
- `ls_size_i` in 3: func3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ls_addr_i` in 32: byte address.
- `ls_wdata_i` in 32: store data, right-aligned.
- `ls_gnt_o` out 1: load/store accepted this cycle.
- `ls_rvalid_o` out 1: load result or error response valid.
- `ls_rdata_o` out 32: extended load data.
- `ls_err_o` out 1: qualifies `ls_rvalid_o`; misaligned or illegal size.
- `mem_req_o` out 1: RAM access this cycle.
- `mem_we_o` out 1: RAM write.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: word address, {addr[31:2],2'b00}.
- `mem_wdata_o` out 32: lane-replicated write data.
- `mem_rdata_i` in 32: read data, valid the cycle after an accepted read.
- `hold_o` out 1: pipeline stall, equal to `ls_req_i & ~ls_gnt_o`.

## Operation
- FSM states:
  - IDLE: no read outstanding.
  - RD_IF: fetch read returning.
  - RD_LS: load read or error returning.
- Arbitration and acceptance:
  - Arbitration is combinational. A new request may be accepted in every state, including in the same cycle a response returns, giving throughput of 1 per cycle.
  - Default priority is LS over IF. If `starve_cnt == STARVE_MAX` and `if_req_i` is high, IF wins, and `starve_cnt` clears on that IF grant.
  - `starve_cnt` increments (saturating at `STARVE_MAX`) each cycle `if_req_i` is high and `if_gnt_o` is low. It clears on any IF grant or when `if_req_i` is low.
  - Exactly one of `if_gnt_o` and `ls_gnt_o` is high when any request is present.
- Errors: an error is LH/LHU with addr[0]=1, LW with addr[1:0]≠0, SH with addr[0]=1, SW with addr[1:0]≠0, or size ∈ {011,110,111}. An erroring request is still granted, `mem_req_o`=0, and the next state is RD_LS with the error flag registered.
- Stores:
  - SB: `mem_be_o` = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
  - A store completes at the grant edge. It produces no `ls_rvalid_o`, and the next state is IDLE unless another read is accepted.
- Loads: grant drives `mem_req_o`=1, `mem_we_o`=0, `mem_be_o`=1111, and registers size and addr[1:0]. Next state is RD_LS.
- Fetch: grant drives a word read. Next state is RD_IF.
- Response phase:
  - RD_IF: `if_rvalid_o`=1, `if_rdata_o`=`mem_rdata_i`.
  - RD_LS without error: `ls_rvalid_o`=1. Data = `mem_rdata_i` >> (8*off), then B sign-extends bit 7, BU zero-extends, H sign-extends bit 15, HU zero-extends, W passes through.
  - RD_LS with error: `ls_rvalid_o`=1, `ls_err_o`=1, `ls_rdata_o`=0.
- Next state: from any state, if a read is accepted go to RD_IF or RD_LS, otherwise go to IDLE.

## Timing
- Reset values: state IDLE, `starve_cnt` 0, registered size/offset/error 0. All `*_rvalid_o`, `ls_err_o` and `*_rdata_o` are 0. Combinational outputs are 0 when no request is present.
- Read latency: grant at cycle N gives rvalid at N+1. Store latency: 0 (write at grant edge).
- Reset asserted mid-read: the outstanding response is dropped, with no rvalid after reset release.
- Simultaneous requests: LS wins unless the starvation condition holds. The loser holds its request and is re-arbitrated the next cycle.
- `hold_o` is combinational and is high in the same cycle a load/store is denied.

## Test plan
- Fetch only, addr 0x10 then 0x14 back-to-back, RAM word 0x00500093 at 0x10 -> gnt both cycles; `if_rvalid_o` at N+1 with 0x00500093; rvalid also at N+2.
- LB at 0x103, RAM word 0x80FF_1234 -> `ls_rdata_o`=0xFFFFFF80 one cycle after grant. LBU at the same address gives 0x00000080; LH at 0x102 gives 0xFFFF80FF.
- SB 0xAB at 0x21 -> `mem_be_o`=0010, `mem_wdata_o`=0xABABABAB, `mem_addr_o`=0x20, no `ls_rvalid_o`. SH at 0x22 -> be=1100.
- LW at 0x06 -> `mem_req_o`=0 on grant; next cycle `ls_rvalid_o`=1, `ls_err_o`=1, data 0. Size 011 gives the same result.
- `if_req_i` and `ls_req_i` both held high for 10 cycles with `STARVE_MAX`=4 -> LS granted cycles 0-3, IF granted cycle 4, pattern repeats; `hold_o`=1 exactly on the IF-granted cycles.
- `rst_n` pulled low in the cycle after a load grant -> no `ls_rvalid_o` after release, state IDLE, counters 0.
